// File: rtl/riscv_defines.sv
// Shared encodings for the EX-stage iterative divider.
// Operator decode helpers live here so the datapath and any consumers agree.
package riscv_defines;

    localparam logic [1:0] DIV_DIV  = 2'b00;
    localparam logic [1:0] DIV_DIVU = 2'b01;
    localparam logic [1:0] DIV_REM  = 2'b10;
    localparam logic [1:0] DIV_REMU = 2'b11;

    localparam int unsigned DIV_STEPS = 32;

    function automatic logic div_op_signed(input logic [1:0] op);
        return (op == DIV_DIV) || (op == DIV_REM);
    endfunction

    function automatic logic div_op_is_rem(input logic [1:0] op);
        return (op == DIV_REM) || (op == DIV_REMU);
    endfunction

endpackage

// File: rtl/riscv_cond_neg.sv
// Combinational 32-bit conditional two's-complement negation.
module riscv_cond_neg (
    input  logic [31:0] in_i,
    input  logic        neg_en_i,
    output logic [31:0] out_o
);

    assign out_o = neg_en_i ? (~in_i + 32'd1) : in_i;

endmodule

// File: rtl/riscv_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Shares the enable/ready/ex_ready multicycle handshake with the EX-stage multiplier.
module riscv_div
    import riscv_defines::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic [1:0]  operator_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic [31:0] result_o,
    output logic        multicycle_o,
    output logic        ready_o,
    input  logic        ex_ready_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIVIDE = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [1:0]  op_q, op_d;
    logic        neg_q_q, neg_q_d;
    logic        neg_r_q, neg_r_d;

    logic        sgn_in;
    logic        b_zero;
    logic        ovf;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [33:0] trial;
    logic [31:0] res_raw;
    logic        res_neg;

    assign sgn_in = div_op_signed(operator_i);
    assign b_zero = (op_b_i == 32'd0);
    assign ovf    = sgn_in && (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF);

    riscv_cond_neg u_abs_a (
        .in_i     (op_a_i),
        .neg_en_i (sgn_in & op_a_i[31]),
        .out_o    (abs_a)
    );

    riscv_cond_neg u_abs_b (
        .in_i     (op_b_i),
        .neg_en_i (sgn_in & op_b_i[31]),
        .out_o    (abs_b)
    );

    // The partial remainder never exceeds the divisor, so rem_q[32] stays zero and the extra borrow bit is exact.
    assign trial = {rem_q, quo_q[31]} - {2'b00, dvs_q};

    assign res_raw = div_op_is_rem(op_q) ? rem_q[31:0] : quo_q;
    assign res_neg = div_op_is_rem(op_q) ? neg_r_q : neg_q_q;

    riscv_cond_neg u_res (
        .in_i     (res_raw),
        .neg_en_i (res_neg),
        .out_o    (result_o)
    );

    // Next-state, datapath step and handshake outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        dvs_d        = dvs_q;
        op_d         = op_q;
        neg_q_d      = neg_q_q;
        neg_r_d      = neg_r_q;
        ready_o      = 1'b0;
        multicycle_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_o = !enable_i;
                if (enable_i) begin
                    op_d  = operator_i;
                    cnt_d = 5'(DIV_STEPS - 1);
                    dvs_d = abs_b;
                    // Special results are stored final, so sign correction is suppressed for them.
                    if (b_zero) begin
                        quo_d   = 32'hFFFF_FFFF;
                        rem_d   = {1'b0, op_a_i};
                        neg_q_d = 1'b0;
                        neg_r_d = 1'b0;
                        state_d = S_FINISH;
                    end else if (ovf) begin
                        quo_d   = 32'h8000_0000;
                        rem_d   = 33'd0;
                        neg_q_d = 1'b0;
                        neg_r_d = 1'b0;
                        state_d = S_FINISH;
                    end else begin
                        quo_d   = abs_a;
                        rem_d   = 33'd0;
                        neg_q_d = sgn_in & (op_a_i[31] ^ op_b_i[31]);
                        neg_r_d = sgn_in & op_a_i[31];
                        state_d = S_DIVIDE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIVIDE: begin
                multicycle_o = 1'b1;
                if (!trial[33]) begin
                    rem_d = trial[32:0];
                end else begin
                    rem_d = {rem_q[31:0], quo_q[31]};
                end
                quo_d = {quo_q[30:0], ~trial[33]};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_DIVIDE;
                end
            end
            S_FINISH: begin
                ready_o = 1'b1;
                if (ex_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FINISH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            rem_q   <= 33'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            op_q    <= 2'b00;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            op_q    <= op_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
        end
    end

endmodule

// File: tb/tb_riscv_div.sv
// Directed and randomised self-checking bench for riscv_div.
module tb_riscv_div;
    import riscv_defines::*;

    logic        clk;
    logic        rst_n;
    logic        enable_i;
    logic [1:0]  operator_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic [31:0] result_o;
    logic        multicycle_o;
    logic        ready_o;
    logic        ex_ready_i;

    int checks;
    int errors;
    int lat;
    int mc;

    riscv_div dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_i),
        .operator_i   (operator_i),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .result_o     (result_o),
        .multicycle_o (multicycle_o),
        .ready_o      (ready_o),
        .ex_ready_i   (ex_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'd0;
        case (op)
            DIV_DIVU: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            DIV_REMU: r = (b == 32'd0) ? a : a % b;
            DIV_DIV: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = $signed(a) / $signed(b);
            end
            default: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = $signed(a) % $signed(b);
            end
        endcase
        return r;
    endfunction

    // Called #1 after a rising edge while the DUT is in IDLE; returns with the DUT in FINISH.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int latency, output int mc_cycles);
        enable_i   = 1'b1;
        operator_i = op;
        op_a_i     = a;
        op_b_i     = b;
        @(posedge clk); #1;
        enable_i   = 1'b0;
        latency    = 1;
        mc_cycles  = int'(multicycle_o);
        while (!ready_o && latency < 100) begin
            @(posedge clk); #1;
            latency++;
            mc_cycles += int'(multicycle_o);
        end
    endtask

    task automatic release_fin();
        ex_ready_i = 1'b1;
        @(posedge clk); #1;
        ex_ready_i = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        enable_i   = 1'b0;
        operator_i = 2'b00;
        op_a_i     = 32'd0;
        op_b_i     = 32'd0;
        ex_ready_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_mc", 32'(multicycle_o), 32'd0);
        check("rst_result", result_o, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(DIV_DIVU, 32'd100, 32'd7, lat, mc);
        check("divu_100_7", result_o, 32'd14);
        check("divu_lat", 32'(lat), 32'd33);
        check("divu_mc", 32'(mc), 32'd32);
        release_fin();
        run_op(DIV_REMU, 32'd100, 32'd7, lat, mc);
        check("remu_100_7", result_o, 32'd2);
        release_fin();

        run_op(DIV_DIV, 32'hFFFF_FF9C, 32'd7, lat, mc);
        check("div_m100_7", result_o, 32'hFFFF_FFF2);
        release_fin();
        run_op(DIV_REM, 32'hFFFF_FF9C, 32'd7, lat, mc);
        check("rem_m100_7", result_o, 32'hFFFF_FFFE);
        release_fin();
        run_op(DIV_REM, 32'd100, 32'hFFFF_FFF9, lat, mc);
        check("rem_100_m7", result_o, 32'd2);
        release_fin();

        run_op(DIV_DIVU, 32'h1234_5678, 32'd0, lat, mc);
        check("divu_by0", result_o, 32'hFFFF_FFFF);
        check("divu_by0_lat", 32'(lat), 32'd1);
        check("divu_by0_mc", 32'(mc), 32'd0);
        release_fin();
        run_op(DIV_REM, 32'hFFFF_FFFB, 32'd0, lat, mc);
        check("rem_by0", result_o, 32'hFFFF_FFFB);
        check("rem_by0_lat", 32'(lat), 32'd1);
        release_fin();

        run_op(DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, mc);
        check("div_ovf", result_o, 32'h8000_0000);
        check("div_ovf_lat", 32'(lat), 32'd1);
        release_fin();
        run_op(DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, mc);
        check("rem_ovf", result_o, 32'd0);
        release_fin();
        run_op(DIV_DIVU, 32'hFFFF_FFFF, 32'd1, lat, mc);
        check("divu_max_1", result_o, 32'hFFFF_FFFF);
        check("divu_max_lat", 32'(lat), 32'd33);
        release_fin();

        // FINISH hold, then release with a request already waiting
        run_op(DIV_DIVU, 32'd1000, 32'd10, lat, mc);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_result", result_o, 32'd100);
            check("hold_ready", 32'(ready_o), 32'd1);
        end
        ex_ready_i = 1'b1;
        enable_i   = 1'b1;
        operator_i = DIV_DIVU;
        op_a_i     = 32'd50;
        op_b_i     = 32'd5;
        @(posedge clk); #1;
        ex_ready_i = 1'b0;
        check("rel_idle_mc", 32'(multicycle_o), 32'd0);
        check("rel_idle_ready", 32'(ready_o), 32'd0);
        @(posedge clk); #1;
        enable_i = 1'b0;
        check("rel_accept_mc", 32'(multicycle_o), 32'd1);
        lat = 1;
        while (!ready_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rel_result", result_o, 32'd10);
        check("rel_lat", 32'(lat), 32'd33);
        release_fin();

        // Reset during DIVIDE
        enable_i   = 1'b1;
        operator_i = DIV_DIVU;
        op_a_i     = 32'hFFFF_FFFF;
        op_b_i     = 32'd3;
        @(posedge clk); #1;
        enable_i = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
        end
        check("mid_mc", 32'(multicycle_o), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_ready", 32'(ready_o), 32'd1);
        check("abort_mc", 32'(multicycle_o), 32'd0);
        check("abort_result", result_o, 32'd0);
        run_op(DIV_DIVU, 32'd9, 32'd3, lat, mc);
        check("post_rst_div", result_o, 32'd3);
        check("post_rst_lat", 32'(lat), 32'd33);
        release_fin();

        for (int i = 0; i < 16; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if (i % 4 == 1) rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            run_op(rop, ra, rb, lat, mc);
            check("random", result_o, ref_div(rop, ra, rb));
            release_fin();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
